sim_ctrl_seq: RTL and testbench

Parametrised successor to the simulation controller. Takes an externally generated clock and sequences DUV reset, counts cycles and emits a programmable heartbeat. It runs a timeout watchdog, aggregates done and error requests from CHANNELS agents, and ends the run through a drain phase with a PASS/FAIL/TIMEOUT verdict. It sits at testbench top, driving the DUV reset and the bench's end-of-simulation logic.

---
 rtl/sim_ctrl_pkg.sv | 25 ++
 rtl/sim_ctrl_sat_cnt.sv | 65 ++++++
 rtl/sim_ctrl_seq.sv | 275 +++++++++++++++++++++++++++
 tb/tb_sim_ctrl_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sim_ctrl_pkg
// Shared types for the simulation controller: FSM state and verdict encodings
// plus their widths. Imported by sim_ctrl_seq.
// -----------------------------------------------------------------------------
package sim_ctrl_pkg;

  localparam int unsigned SIM_CTRL_STATE_W  = 2;
  localparam int unsigned SIM_CTRL_STATUS_W = 2;

  typedef enum logic [SIM_CTRL_STATE_W-1:0] {
    ST_RESET  = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } sim_ctrl_state_t;

  typedef enum logic [SIM_CTRL_STATUS_W-1:0] {
    VERDICT_NONE    = 2'd0,
    VERDICT_PASS    = 2'd1,
    VERDICT_FAIL    = 2'd2,
    VERDICT_TIMEOUT = 2'd3
  } sim_ctrl_status_t;

endpackage : sim_ctrl_pkg

// File: rtl/sim_ctrl_sat_cnt.sv
// -----------------------------------------------------------------------------
// sim_ctrl_sat_cnt
// Saturating accumulator. Adds i_inc to the count on every enabled edge and
// sticks at all-ones instead of wrapping. i_clr synchronously zeroes the
// count and has priority over i_en.
//
// Ports:
//   i_clk   clock
//   i_rst_n asynchronous active-low reset (count -> 0)
//   i_en    accumulate enable
//   i_clr   synchronous clear
//   i_inc   increment value (INC_W bits, zero-extended)
//   o_cnt   registered count
//   o_nxt   value the count takes on the next edge (combinational)
// -----------------------------------------------------------------------------
module sim_ctrl_sat_cnt #(
  parameter int unsigned W     = 32,
  parameter int unsigned INC_W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [INC_W-1:0] i_inc,
  output logic [W-1:0]     o_cnt,
  output logic [W-1:0]     o_nxt
);

  // One spare bit above the wider operand catches the carry out of W bits.
  localparam int unsigned SUM_W = ((W > INC_W) ? W : INC_W) + 1;

  logic [W-1:0]     r_cnt;
  logic [SUM_W-1:0] w_sum;
  logic [W-1:0]     w_nxt;

  // Next count: clear, saturating add, or hold.
  always_comb begin
    w_sum = SUM_W'(r_cnt) + SUM_W'(i_inc);
    w_nxt = r_cnt;
    if (i_clr) begin
      w_nxt = '0;
    end else if (i_en) begin
      if (w_sum[SUM_W-1:W] != '0) begin
        w_nxt = '1;
      end else begin
        w_nxt = w_sum[W-1:0];
      end
    end else begin
      w_nxt = r_cnt;
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_nxt;
    end
  end

  assign o_cnt = r_cnt;
  assign o_nxt = w_nxt;

endmodule : sim_ctrl_sat_cnt

// File: rtl/sim_ctrl_seq.sv
// -----------------------------------------------------------------------------
// sim_ctrl_seq
// Testbench-top simulation controller. Sequences the DUV reset, counts cycles,
// emits a programmable heartbeat, runs a timeout watchdog, aggregates done and
// error requests from CHANNELS agents and ends the run through a drain phase
// with a PASS / FAIL / TIMEOUT verdict.
//
// Optional build macro: SIM_CTRL_SEQ_ERR_LIMIT_EN
//   defined   -> error total reaching ERR_LIMIT in RUN/DRAIN aborts with FAIL
//   undefined -> errors are only counted; verdict taken at drain end
//
// Ports:
//   sim_ctrl_clk_ip    clock
//   sim_ctrl_rstn_ip   asynchronous active-low reset
//   cfg_rst_cycles_ip  DUV reset length (cycles), live while in RESET
//   cfg_timeout_ip     timeout cycle count, 0 = disabled (frozen at RUN entry)
//   cfg_freq_ip        heartbeat period, 0 = disabled (frozen at RUN entry)
//   done_req_ip        per-agent done level
//   err_ip             per-agent error pulse
//   duv_rst_op         active-high DUV reset
//   cycles_op          cycles since reset release (saturating, frozen in FINISH)
//   heartbeat_op       one-cycle heartbeat pulse
//   state_op           FSM state
//   status_op          verdict
//   finish_op          one-cycle pulse the cycle after FINISH is entered
//   err_count_op       saturating error total
// -----------------------------------------------------------------------------
module sim_ctrl_seq
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned CYCLE_W      = 32,
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned DRAIN_CYCLES = 16,
  parameter int unsigned ERR_LIMIT    = 1
) (
  input  logic                         sim_ctrl_clk_ip,
  input  logic                         sim_ctrl_rstn_ip,
  input  logic [CYCLE_W-1:0]           cfg_rst_cycles_ip,
  input  logic [CYCLE_W-1:0]           cfg_timeout_ip,
  input  logic [CYCLE_W-1:0]           cfg_freq_ip,
  input  logic [CHANNELS-1:0]          done_req_ip,
  input  logic [CHANNELS-1:0]          err_ip,
  output logic                         duv_rst_op,
  output logic [CYCLE_W-1:0]           cycles_op,
  output logic                         heartbeat_op,
  output logic [SIM_CTRL_STATE_W-1:0]  state_op,
  output logic [SIM_CTRL_STATUS_W-1:0] status_op,
  output logic                         finish_op,
  output logic [CYCLE_W-1:0]           err_count_op
);

  localparam int unsigned POP_W = $clog2(CHANNELS + 1);
  localparam int unsigned DRN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DRN_W-1:0]   DRN_LOAD = DRN_W'(DRAIN_CYCLES);
  localparam logic [DRN_W-1:0]   DRN_ONE  = DRN_W'(1);
  localparam logic [CYCLE_W-1:0] ERR_LIM  = CYCLE_W'(ERR_LIMIT);
  localparam logic [CYCLE_W:0]   PH_ONE   = {{CYCLE_W{1'b0}}, 1'b1};

`ifdef SIM_CTRL_SEQ_ERR_LIMIT_EN
  localparam bit ERR_LIMIT_EN = 1'b1;
`else
  localparam bit ERR_LIMIT_EN = 1'b0;
`endif

  // Number of set bits in the per-agent error vector.
  function automatic logic [POP_W-1:0] popcount(input logic [CHANNELS-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

  sim_ctrl_state_t   r_state;
  sim_ctrl_state_t   w_state_nxt;
  sim_ctrl_status_t  r_status;
  sim_ctrl_status_t  w_status_nxt;
  sim_ctrl_status_t  w_verdict;

  logic [CYCLE_W-1:0] r_cfg_timeout;
  logic [CYCLE_W-1:0] r_cfg_freq;
  logic [DRN_W-1:0]   r_drain_cnt;
  logic [DRN_W-1:0]   w_drain_nxt;
  logic [CYCLE_W-1:0] r_hb_phase;
  logic [CYCLE_W-1:0] w_hb_phase_nxt;
  logic [CYCLE_W:0]   w_phase_inc;
  logic [CYCLE_W-1:0] w_freq;
  logic               r_heartbeat;
  logic               w_hb_nxt;
  logic               r_finish;
  logic               r_fin_seen;
  logic               r_duv_rst;

  logic [CYCLE_W-1:0] w_cycles;
  logic [CYCLE_W-1:0] w_cyc_nxt;
  logic [CYCLE_W-1:0] w_err_cnt;
  logic [CYCLE_W-1:0] w_err_nxt;
  logic               w_active;
  logic               w_cyc_en;
  logic               w_timeout_hit;
  logic               w_limit_hit;

  assign w_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_cyc_en = (r_state != ST_FINISH);

  sim_ctrl_sat_cnt #(
    .W     (CYCLE_W),
    .INC_W (1)
  ) u_cycle_cnt (
    .i_clk   (sim_ctrl_clk_ip),
    .i_rst_n (sim_ctrl_rstn_ip),
    .i_en    (w_cyc_en),
    .i_clr   (1'b0),
    .i_inc   (1'b1),
    .o_cnt   (w_cycles),
    .o_nxt   (w_cyc_nxt)
  );

  sim_ctrl_sat_cnt #(
    .W     (CYCLE_W),
    .INC_W (POP_W)
  ) u_err_cnt (
    .i_clk   (sim_ctrl_clk_ip),
    .i_rst_n (sim_ctrl_rstn_ip),
    .i_en    (w_active),
    .i_clr   (1'b0),
    .i_inc   (popcount(err_ip)),
    .o_cnt   (w_err_cnt),
    .o_nxt   (w_err_nxt)
  );

  // Abort conditions and the drain-end verdict. The verdict and limit use the
  // post-update error total so errors on the deciding edge are included.
  always_comb begin
    w_timeout_hit = (r_cfg_timeout != '0) && (w_cycles >= r_cfg_timeout);
    w_limit_hit   = ERR_LIMIT_EN && (w_err_nxt >= ERR_LIM);
    if (w_err_nxt == '0) begin
      w_verdict = VERDICT_PASS;
    end else begin
      w_verdict = VERDICT_FAIL;
    end
  end

  // Next-state, verdict and drain counter. Priority: timeout > error limit >
  // done/drain expiry.
  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    w_drain_nxt  = r_drain_cnt;
    case (r_state)
      ST_RESET: begin
        // Saturated next count is all-ones, which still satisfies >= any length.
        if (w_cyc_nxt >= cfg_rst_cycles_ip) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_RESET;
        end
      end
      ST_RUN: begin
        if (w_timeout_hit) begin
          w_state_nxt  = ST_FINISH;
          w_status_nxt = VERDICT_TIMEOUT;
        end else if (w_limit_hit) begin
          w_state_nxt  = ST_FINISH;
          w_status_nxt = VERDICT_FAIL;
        end else if (&done_req_ip) begin
          if (DRAIN_CYCLES == 0) begin
            w_state_nxt  = ST_FINISH;
            w_status_nxt = w_verdict;
          end else begin
            w_state_nxt = ST_DRAIN;
            w_drain_nxt = DRN_LOAD;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt != '0) begin
          w_drain_nxt = r_drain_cnt - DRN_ONE;
        end else begin
          w_drain_nxt = '0;
        end
        if (w_timeout_hit) begin
          w_state_nxt  = ST_FINISH;
          w_status_nxt = VERDICT_TIMEOUT;
        end else if (w_limit_hit) begin
          w_state_nxt  = ST_FINISH;
          w_status_nxt = VERDICT_FAIL;
        end else if (r_drain_cnt <= DRN_ONE) begin
          // Counter reaches zero on this edge.
          w_state_nxt  = ST_FINISH;
          w_status_nxt = w_verdict;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_FINISH: begin
        w_state_nxt = ST_FINISH;
      end
      default: begin
        w_state_nxt  = ST_RESET;
        w_status_nxt = VERDICT_NONE;
        w_drain_nxt  = '0;
      end
    endcase
  end

  // Heartbeat: r_hb_phase tracks cycles_op modulo the period without a
  // divider. In RESET the live period is used (it is expected stable there);
  // it becomes the frozen period on the RESET->RUN edge. The phase holds when
  // the cycle count does not advance (saturated or FINISH).
  always_comb begin
    if (r_state == ST_RESET) begin
      w_freq = cfg_freq_ip;
    end else begin
      w_freq = r_cfg_freq;
    end
    w_phase_inc = {1'b0, r_hb_phase} + PH_ONE;
    if (w_cyc_nxt == w_cycles) begin
      w_hb_phase_nxt = r_hb_phase;
    end else if (w_phase_inc >= {1'b0, w_freq}) begin
      w_hb_phase_nxt = '0;
    end else begin
      w_hb_phase_nxt = w_phase_inc[CYCLE_W-1:0];
    end
    w_hb_nxt = ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN)) &&
               (w_freq != '0) && (w_hb_phase_nxt == '0) && (w_cyc_nxt != '0);
  end

  // State, verdict, frozen configuration and registered outputs.
  always_ff @(posedge sim_ctrl_clk_ip or negedge sim_ctrl_rstn_ip) begin
    if (!sim_ctrl_rstn_ip) begin
      r_state       <= ST_RESET;
      r_status      <= VERDICT_NONE;
      r_cfg_timeout <= '0;
      r_cfg_freq    <= '0;
      r_drain_cnt   <= '0;
      r_hb_phase    <= '0;
      r_heartbeat   <= 1'b0;
      r_finish      <= 1'b0;
      r_fin_seen    <= 1'b0;
      r_duv_rst     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_status    <= w_status_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_hb_phase  <= w_hb_phase_nxt;
      r_heartbeat <= w_hb_nxt;
      r_duv_rst   <= (w_state_nxt == ST_RESET);
      // Pulse in the cycle following the first FINISH cycle.
      r_finish    <= (r_state == ST_FINISH) && !r_fin_seen;
      r_fin_seen  <= (r_state == ST_FINISH);
      // Config follows the inputs throughout RESET; the last sample taken is
      // the one on the RESET->RUN edge.
      if (r_state == ST_RESET) begin
        r_cfg_timeout <= cfg_timeout_ip;
        r_cfg_freq    <= cfg_freq_ip;
      end else begin
        r_cfg_timeout <= r_cfg_timeout;
        r_cfg_freq    <= r_cfg_freq;
      end
    end
  end

  assign duv_rst_op   = r_duv_rst;
  assign cycles_op    = w_cycles;
  assign heartbeat_op = r_heartbeat;
  assign state_op     = r_state;
  assign status_op    = r_status;
  assign finish_op    = r_finish;
  assign err_count_op = w_err_cnt;

endmodule : sim_ctrl_seq

// File: tb/tb_sim_ctrl_seq.sv
// Bench for sim_ctrl_seq with default parameters (CYCLE_W=32, CHANNELS=4,
// DRAIN_CYCLES=16). Cycle k means cycles_op==k after reset release; inputs
// for cycle k are driven on its falling edge and act on the following rising
// edge. Outputs are sampled on falling edges.
module tb_sim_ctrl_seq;

  logic        clk;
  logic        rstn;
  logic [31:0] cfg_rst;
  logic [31:0] cfg_to;
  logic [31:0] cfg_freq;
  logic [3:0]  done_req;
  logic [3:0]  err;
  logic        duv_rst;
  logic [31:0] cycles;
  logic        hb;
  logic [1:0]  state;
  logic [1:0]  status;
  logic        finish;
  logic [31:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  sim_ctrl_seq #(
    .CYCLE_W      (32),
    .CHANNELS     (4),
    .DRAIN_CYCLES (16),
    .ERR_LIMIT    (1)
  ) dut (
    .sim_ctrl_clk_ip   (clk),
    .sim_ctrl_rstn_ip  (rstn),
    .cfg_rst_cycles_ip (cfg_rst),
    .cfg_timeout_ip    (cfg_to),
    .cfg_freq_ip       (cfg_freq),
    .done_req_ip       (done_req),
    .err_ip            (err),
    .duv_rst_op        (duv_rst),
    .cycles_op         (cycles),
    .heartbeat_op      (hb),
    .state_op          (state),
    .status_op         (status),
    .finish_op         (finish),
    .err_count_op      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One test vector: configuration, stimulus windows and expected milestones.
  // exp_drain/exp_fin = -1 means that state is never reached.
  typedef struct {
    int rst; int to; int freq;
    int done_from; int done_to;
    int err_from; int err_to; int err_val;
    int chg_at; int n_cyc;
    int exp_drain; int exp_fin; int exp_status; int exp_err;
  } vec_t;

  typedef struct {
    int pulse; int status; int err; int cyc;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[12];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int r_len;
    int est;
    int ehb;
    exp_t e;
    r_len = (v.rst < 1) ? 1 : v.rst;
    rstn     = 1'b0;
    cfg_rst  = 32'(v.rst);
    cfg_to   = 32'(v.to);
    cfg_freq = 32'(v.freq);
    done_req = 4'b0000;
    err      = 4'b0000;
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    if (v.exp_fin >= 0) begin
      e.pulse  = v.exp_fin + 1;
      e.status = v.exp_status;
      e.err    = v.exp_err;
      e.cyc    = v.exp_fin;
      sb_q.push_back(e);
    end
    #1;
    for (int k = 0; k < v.n_cyc; k++) begin
      if (k < r_len) est = 0;
      else if (v.exp_fin >= 0 && k >= v.exp_fin) est = 3;
      else if (v.exp_drain >= 0 && k >= v.exp_drain) est = 2;
      else est = 1;
      ehb = (v.freq != 0 && (k % v.freq) == 0 && k != 0 && (est == 1 || est == 2)) ? 1 : 0;
      chk($sformatf("v%0d c%0d duv_rst", vi, k), duv_rst, (k < r_len) ? 1 : 0);
      chk($sformatf("v%0d c%0d state", vi, k), state, est);
      chk($sformatf("v%0d c%0d cycles", vi, k), cycles,
          (v.exp_fin >= 0 && k >= v.exp_fin) ? v.exp_fin : k);
      chk($sformatf("v%0d c%0d heartbeat", vi, k), hb, ehb);
      chk($sformatf("v%0d c%0d status", vi, k), status,
          (v.exp_fin >= 0 && k >= v.exp_fin) ? v.exp_status : 0);
      if (finish) begin
        if (sb_q.size() == 0) begin
          chk($sformatf("v%0d c%0d unexpected finish", vi, k), 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("v%0d finish cycle", vi), k, e.pulse);
          chk($sformatf("v%0d finish status", vi), status, e.status);
          chk($sformatf("v%0d finish err_count", vi), err_cnt, e.err);
          chk($sformatf("v%0d finish cycles", vi), cycles, e.cyc);
        end
      end
      // Inputs for cycle k.
      done_req = (k >= v.done_from && k <= v.done_to) ? 4'b1111 : 4'b0000;
      err      = (k >= v.err_from && k <= v.err_to) ? 4'(v.err_val) : 4'b0000;
      if (k == v.chg_at) begin
        cfg_rst  = 32'd1;
        cfg_to   = 32'd3;
        cfg_freq = 32'd2;
      end
      @(negedge clk);
      #1;
    end
    chk($sformatf("v%0d finish pulses outstanding", vi), sb_q.size(), 0);
    chk($sformatf("v%0d final err_count", vi), err_cnt, v.exp_err);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t g;
    rstn = 1'b0; cfg_rst = '0; cfg_to = '0; cfg_freq = '0;
    done_req = '0; err = '0;

    //        rst  to   f  dfrom dto   efrom eto  eval  chg  n    drn  fin  st  err
    vecs[0]  = '{5,   0,   0, -1,   -2,   -1,   -2,  0,   -1,  50,  -1,  -1,  0,  0};
    vecs[1]  = '{0,   0,   0, -1,   -2,   -1,   -2,  0,   -1,  10,  -1,  -1,  0,  0};
    vecs[2]  = '{5,   0,   0, 20,   20,   -1,   -2,  0,   -1,  50,  21,  37,  1,  0};
    vecs[3]  = '{5,   100, 0, -1,   -2,   -1,   -2,  0,   -1,  110, -1,  101, 3,  0};
    vecs[4]  = '{5,   100, 0, 95,   1000, -1,   -2,  0,   -1,  110, 96,  101, 3,  0};
`ifdef SIM_CTRL_SEQ_ERR_LIMIT_EN
    vecs[5]  = '{5,   0,   0, 20,   1000, 10,   12,  5,   -1,  50,  -1,  11,  2,  2};
`else
    vecs[5]  = '{5,   0,   0, 20,   1000, 10,   12,  5,   -1,  50,  21,  37,  2,  6};
`endif
    vecs[6]  = '{5,   0,   0, 20,   1000, 36,   36,  8,   -1,  50,  21,  37,  2,  1};
    vecs[7]  = '{5,   0,   0, 20,   1000, 0,    4,   15,  -1,  50,  21,  37,  1,  0};
    vecs[8]  = '{5,   0,   0, 20,   1000, 37,   45,  15,  -1,  50,  21,  37,  1,  0};
    vecs[9]  = '{5,   30,  0, 30,   1000, -1,   -2,  0,   -1,  45,  -1,  31,  3,  0};
    vecs[10] = '{5,   0,   7, 20,   1000, -1,   -2,  0,   8,   50,  21,  37,  1,  0};
    vecs[11] = '{3,   0,   1, 3,    1000, -1,   -2,  0,   -1,  30,  4,   20,  1,  0};

    for (int i = 0; i < 12; i++) begin
      run_vec(i, vecs[i]);
    end

    // Heartbeat to cycle 34, then async reset in the middle of cycle 35.
    g = '{5, 0, 10, -1, -2, -1, -2, 0, -1, 35, -1, -1, 0, 0};
    run_vec(12, g);
    chk("mid cycles before reset", cycles, 35);
    chk("mid state before reset", state, 1);
    rstn = 1'b0;
    #1;
    chk("async duv_rst", duv_rst, 1);
    chk("async cycles", cycles, 0);
    chk("async heartbeat", hb, 0);
    chk("async state", state, 0);
    chk("async status", status, 0);
    chk("async finish", finish, 0);
    chk("async err_count", err_cnt, 0);
    // New configuration must be picked up after the reset.
    cfg_rst = 32'd2; cfg_freq = 32'd3; cfg_to = 32'd0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("resample state c2", state, 1);
    chk("resample duv_rst c2", duv_rst, 0);
    chk("resample heartbeat c2", hb, 0);
    @(negedge clk);
    #1;
    chk("resample cycles c3", cycles, 3);
    chk("resample heartbeat c3", hb, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sim_ctrl_seq
